sap1_datapath: RTL and testbench

//   Downstream consumer of the SAP-1 controller's 12-bit control word. Holds the PC, MAR, 16x8 RAM,
//   IR, A, B and adder/subtractor on a shared 8-bit bus; returns the IR opcode nibble to the controller.

---
 rtl/sap1_datapath.sv | 122 ++++++++++++
 tb/tb_sap1_datapath.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B and adder/subtractor around a shared bus.
// Define SAP1_FLAGS_EN to add the carry/zero flag registers and their flag_c/flag_z outputs.
module sap1_datapath #(
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       ctrl,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] a_out,
    output logic              halted,
    output logic              bus_conflict
`ifdef SAP1_FLAGS_EN
    ,
    output logic              flag_c,
    output logic              flag_z
`endif
);

    logic hlt, pc_inc, pc_en, mem_load, mem_en, ir_load, ir_en;
    logic a_load, a_en, b_load, adder_sub, adder_en;

    assign hlt       = ctrl[11];
    assign pc_inc    = ctrl[10];
    assign pc_en     = ctrl[9];
    assign mem_load  = ctrl[8];
    assign mem_en    = ctrl[7];
    assign ir_load   = ctrl[6];
    assign ir_en     = ctrl[5];
    assign a_load    = ctrl[4];
    assign a_en      = ctrl[3];
    assign b_load    = ctrl[2];
    assign adder_sub = ctrl[1];
    assign adder_en  = ctrl[0];

    logic [3:0]        pc;
    logic [3:0]        mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic [DATA_W-1:0] sum;
    logic [4:0]        bus_drivers;

    // Subtraction is a + ~b + 1; the extra top bit is the carry (1 = no borrow).
`ifdef SAP1_FLAGS_EN
    logic [DATA_W:0] sum_full;
    logic            carry;
    assign sum_full = {1'b0, a} + {1'b0, (adder_sub ? ~b : b)} + {{DATA_W{1'b0}}, adder_sub};
    assign sum      = sum_full[DATA_W-1:0];
    assign carry    = sum_full[DATA_W];
`else
    assign sum = a + (adder_sub ? ~b : b) + {{(DATA_W-1){1'b0}}, adder_sub};
`endif

    always_comb begin
        bus = '0;
        if (pc_en)
            bus = {{(DATA_W-4){1'b0}}, pc};
        else if (mem_en)
            bus = ram[mar];
        else if (ir_en)
            bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
        else if (a_en)
            bus = a;
        else if (adder_en)
            bus = sum;
    end

    // Clearing the lowest set bit leaves something only if two or more drivers are on.
    assign bus_drivers  = {pc_en, mem_en, ir_en, a_en, adder_en};
    assign bus_conflict = |(bus_drivers & (bus_drivers - 5'd1));

    assign opcode = ir[DATA_W-1:DATA_W-4];
    assign a_out  = a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            mar    <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            halted <= 1'b0;
        end else if (!prog_mode && !halted) begin
            if (hlt) begin
                halted <= 1'b1;
            end else begin
                if (mem_load) mar <= bus[3:0];
                if (ir_load)  ir  <= bus;
                if (a_load)   a   <= bus;
                if (b_load)   b   <= bus;
                if (pc_inc)   pc  <= pc + 4'd1;
            end
        end
    end

`ifdef SAP1_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (!prog_mode && !halted && !hlt && adder_en && a_load) begin
            flag_c <= carry;
            flag_z <= (sum == '0);
        end
    end
`endif

    // Program-load port; RAM has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (prog_mode && prog_we)
            ram[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_sap1_datapath.sv
// Self-checking bench for sap1_datapath: a high-level model pushes the expected per-cycle view into a queue,
// and an independent monitor samples the DUT mid-cycle and compares against it.
module tb_sap1_datapath;

    localparam int OBS_W = 24;
`ifdef SAP1_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ctrl;
    logic        prog_mode;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [7:0]  bus;
    logic [7:0]  a_out;
    logic        halted;
    logic        bus_conflict;
    logic        flag_c_s;
    logic        flag_z_s;

`ifdef SAP1_FLAGS_EN
    logic flag_c, flag_z;
    assign flag_c_s = flag_c;
    assign flag_z_s = flag_z;
`else
    assign flag_c_s = 1'b0;
    assign flag_z_s = 1'b0;
`endif

    sap1_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl         (ctrl),
        .prog_mode    (prog_mode),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .bus          (bus),
        .a_out        (a_out),
        .halted       (halted),
        .bus_conflict (bus_conflict)
`ifdef SAP1_FLAGS_EN
        ,
        .flag_c       (flag_c),
        .flag_z       (flag_z)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [OBS_W-1:0] exp_q[$];
    string            name_q[$];
    int               checks   = 0;
    int               failures = 0;

    // Reference model: architectural registers as plain integers
    int m_pc, m_mar, m_ir, m_a, m_b;
    bit m_halt, m_fc, m_fz;
    int mem[16];

    function automatic int m_sum(input logic [11:0] c);
        if (c[1]) return (m_a - m_b + 256) % 256;
        return (m_a + m_b) % 256;
    endfunction

    function automatic bit m_carry(input logic [11:0] c);
        if (c[1]) return (m_a >= m_b);
        return (m_a + m_b > 255);
    endfunction

    function automatic int m_bus(input logic [11:0] c);
        if (c[9]) return m_pc;
        if (c[7]) return mem[m_mar];
        if (c[5]) return m_ir % 16;
        if (c[3]) return m_a;
        if (c[0]) return m_sum(c);
        return 0;
    endfunction

    function automatic bit m_conflict(input logic [11:0] c);
        int n;
        n = int'(c[9]) + int'(c[7]) + int'(c[5]) + int'(c[3]) + int'(c[0]);
        return (n >= 2);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
        m_halt = 1'b0; m_fc = 1'b0; m_fz = 1'b0;
    endtask

    // One clock cycle: optional async reset pulse, drive inputs, record expected view, advance the model.
    task automatic cycle(input logic [11:0] c, input bit pm, input bit we, input int addr,
                         input int data, input bit do_rst, input string name);
        int bv;
        logic [OBS_W-1:0] e;
        @(negedge clk);
        if (do_rst) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
            model_reset();
        end
        ctrl      = c;
        prog_mode = pm;
        prog_we   = we;
        prog_addr = 4'(addr);
        prog_data = 8'(data);
        bv = m_bus(c);
        e = {8'(bv), 8'(m_a), 4'(m_ir / 16), m_halt, m_conflict(c),
             FLAGS_ON & m_fc, FLAGS_ON & m_fz};
        exp_q.push_back(e);
        name_q.push_back(name);
        if (!pm && !m_halt) begin
            if (c[11]) begin
                m_halt = 1'b1;
            end else begin
                if (c[0] && c[4]) begin
                    m_fc = m_carry(c);
                    m_fz = (m_sum(c) == 0);
                end
                if (c[8])  m_mar = bv % 16;
                if (c[6])  m_ir  = bv;
                if (c[4])  m_a   = bv;
                if (c[2])  m_b   = bv;
                if (c[10]) m_pc  = (m_pc + 1) % 16;
            end
        end
        if (pm && we) mem[addr % 16] = data % 256;
    endtask

    task automatic run(input logic [11:0] c, input string name);
        cycle(c, 1'b0, 1'b0, 0, 0, 1'b0, name);
    endtask

    task automatic prog(input int addr, input int data);
        cycle(12'h000, 1'b1, 1'b1, addr, data, 1'b0, "prog_load");
    endtask

    task automatic do_reset(input string name);
        cycle(12'h000, 1'b0, 1'b0, 0, 0, 1'b1, name);
    endtask

    task automatic fetch();
        run(12'h300, "fetch_t1");
        run(12'h400, "fetch_t2");
        run(12'h0C0, "fetch_t3");
    endtask

    task automatic exec_lda();
        run(12'h120, "lda_t4");
        run(12'h090, "lda_t5");
    endtask

    task automatic exec_alu(input bit sub);
        run(12'h120, "alu_t4");
        run(12'h084, "alu_t5");
        run(sub ? 12'h013 : 12'h011, sub ? "sub_t6" : "add_t6");
    endtask

    // Monitor: samples the DUT a little after each falling edge, when inputs are settled.
    initial begin
        logic [OBS_W-1:0] exp_v, act_v;
        string            nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {bus, a_out, opcode, halted, bus_conflict, flag_c_s, flag_z_s};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s: got bus/a/op/hlt/conf/c/z=%h expected %h (t=%0t)",
                             nm, act_v, exp_v, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [11:0] c;
        bit          pm;
        bit          rs;

        rst = 1'b1; ctrl = '0; prog_mode = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0;
        model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run(12'h000, "reset_state");
        run(12'h200, "reset_pc");

        // Program: LDA 9, ADD A, SUB B, HLT with data at 9..11; remaining words random.
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       prog(i, 8'h09);
                1:       prog(i, 8'h1A);
                2:       prog(i, 8'h2B);
                3:       prog(i, 8'hF0);
                9:       prog(i, 8'h10);
                10:      prog(i, 8'h05);
                11:      prog(i, 8'h03);
                default: prog(i, int'($urandom_range(0, 255)));
            endcase
        end

        // Async reset pulse between edges clears registers but not RAM.
        run(12'h300, "pre_rst_t1");
        run(12'h400, "pre_rst_t2");
        run(12'h0C0, "pre_rst_ir");
        run(12'h090, "pre_rst_a");
        do_reset("async_reset");
        run(12'h200, "pc_after_rst");
        run(12'h080, "ram_intact");

        fetch(); exec_lda();
        fetch(); exec_alu(1'b0);
        fetch(); exec_alu(1'b1);
        fetch(); run(12'h800, "hlt");
        run(12'h200, "halt_pc");
        run(12'h000, "halt_a");
        for (int i = 0; i < 6; i++) run(12'($urandom_range(0, 4095)), "halt_hold");

        // Overflow/underflow with flags: FF+01, then 03-05.
        do_reset("rst_flags");
        prog(0, 8'h0C); prog(1, 8'h1D); prog(2, 8'h0E); prog(3, 8'h2F);
        prog(12, 8'hFF); prog(13, 8'h01); prog(14, 8'h03); prog(15, 8'h05);
        fetch(); exec_lda();
        fetch(); exec_alu(1'b0);
        run(12'h000, "add_wrap");
        fetch(); exec_lda();
        fetch(); exec_alu(1'b1);
        run(12'h000, "sub_borrow");

        // PC wrap and bus priority under conflict.
        do_reset("rst_pc");
        for (int i = 0; i < 15; i++) run(12'h400, "pc_inc");
        run(12'h200, "pc_15");
        run(12'h280, "pc_mem_conflict");
        run(12'h400, "pc_wrap");
        run(12'h200, "pc_0");

        // HLT suppresses the other loads in its cycle.
        run(12'h080, "mem_read");
        run(12'h090, "load_a");
        run(12'hC11, "hlt_with_loads");
        run(12'h200, "hlt_pc_kept");
        run(12'h094, "hlt_ignores");
        run(12'h000, "hlt_a_kept");

        // prog_we ignored outside prog_mode; ctrl ignored inside it.
        do_reset("rst_prog");
        cycle(12'h000, 1'b0, 1'b1, 0, 8'hAA, 1'b0, "we_no_prog");
        run(12'h080, "ram_unchanged");
        run(12'h090, "load_a2");
        cycle(12'h014, 1'b1, 1'b0, 0, 0, 1'b0, "prog_freeze");
        run(12'h000, "a_frozen");

        // Randomized control words against the model.
        for (int i = 0; i < 400; i++) begin
            c  = 12'($urandom_range(0, 4095));
            c[11] = ($urandom_range(0, 39) == 0);
            pm = ($urandom_range(0, 7) == 0);
            if (pm) c = c & 12'hD56;
            rs = m_halt && ($urandom_range(0, 3) == 0);
            cycle(c, pm, bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), rs, "random");
        end

        @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
